pc_redirect_fetch: RTL and testbench

- Program-counter and IF/ID boundary for the pipelined SAD datapath.
- Consumes the 28-bit shifted jump field from the jump-target shifter, branch and jump-register redirects, and hazard stall.
- Produces the fetch PC for instruction memory and the registered IF/ID instruction/PC+4 pair.
- Resolves redirect priority and inserts bubbles on taken control transfers.

---
 rtl/pc_redirect_fetch.sv | 89 ++++++++
 tb/tb_pc_redirect_fetch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_fetch.sv
// Fetch program counter with redirect priority (jr > branch > jump > stall)
// and the IF/ID pipeline register, flushed to a bubble on any taken redirect.
module pc_redirect_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [31:0] Instr,
  input  logic        JumpEn,
  input  logic [27:0] JumpTarget28,
  input  logic        BranchTaken,
  input  logic [31:0] BranchBase,
  input  logic [31:0] BranchOffset,
  input  logic        JrEn,
  input  logic [31:0] JrAddr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Redirect
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic [31:0] ifid_pcplus4_reg, ifid_pcplus4_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic [31:0] pc_plus4;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic        redirect;

  assign pc_plus4    = pc_reg + 32'd4;
  assign branch_addr = BranchBase + BranchOffset;
  // The jump's region nibble belongs to the jump instruction itself, which sits in IF/ID.
  assign jump_addr   = {ifid_pcplus4_reg[31:28], JumpTarget28};
  assign redirect    = JrEn | BranchTaken | JumpEn;

  always_comb begin
    pc_next           = pc_plus4;
    ifid_instr_next   = Instr;
    ifid_pcplus4_next = pc_plus4;
    ifid_valid_next   = 1'b1;

    if (JrEn) begin
      pc_next = JrAddr;
    end else if (BranchTaken) begin
      pc_next = branch_addr;
    end else if (JumpEn) begin
      pc_next = jump_addr;
    end else if (Stall) begin
      pc_next = pc_reg;
    end

    if (redirect) begin
      ifid_instr_next   = NOP_INSTR;
      ifid_pcplus4_next = 32'd0;
      ifid_valid_next   = 1'b0;
    end else if (Stall) begin
      ifid_instr_next   = ifid_instr_reg;
      ifid_pcplus4_next = ifid_pcplus4_reg;
      ifid_valid_next   = ifid_valid_reg;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_reg           <= RESET_PC;
      ifid_instr_reg   <= NOP_INSTR;
      ifid_pcplus4_reg <= 32'd0;
      ifid_valid_reg   <= 1'b0;
    end else begin
      pc_reg           <= pc_next;
      ifid_instr_reg   <= ifid_instr_next;
      ifid_pcplus4_reg <= ifid_pcplus4_next;
      ifid_valid_reg   <= ifid_valid_next;
    end
  end

  assign PC           = pc_reg;
  assign PCPlus4      = pc_plus4;
  assign IFID_Instr   = ifid_instr_reg;
  assign IFID_PCPlus4 = ifid_pcplus4_reg;
  assign IFID_Valid   = ifid_valid_reg;
  assign Redirect     = redirect;

endmodule

// File: tb/tb_pc_redirect_fetch.sv
// Bench for pc_redirect_fetch: a reference model pushes the expected state per
// edge into a scoreboard queue; each scenario task also checks its key values.
module tb_pc_redirect_fetch;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic [31:0] Instr;
  logic        JumpEn = 1'b0;
  logic [27:0] JumpTarget28 = '0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchBase = '0;
  logic [31:0] BranchOffset = '0;
  logic        JrEn = 1'b0;
  logic [31:0] JrAddr = '0;
  logic [31:0] PC, PCPlus4, IFID_Instr, IFID_PCPlus4;
  logic        IFID_Valid, Redirect;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  bit          m_init = 0;

  pc_redirect_fetch dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Instr(Instr),
    .JumpEn(JumpEn), .JumpTarget28(JumpTarget28),
    .BranchTaken(BranchTaken), .BranchBase(BranchBase), .BranchOffset(BranchOffset),
    .JrEn(JrEn), .JrAddr(JrAddr),
    .PC(PC), .PCPlus4(PCPlus4), .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid), .Redirect(Redirect)
  );

  always #5 Clk = ~Clk;

  // Behavioural instruction memory: address 0 holds the first test-plan instruction.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'd0) return 32'h2008_0005;
    return 32'h8C00_0000 ^ {a[15:0], a[31:16]};
  endfunction

  assign Instr = imem(PC);

  task automatic clear_inputs();
    Reset = 0; Stall = 0; JumpEn = 0; BranchTaken = 0; JrEn = 0;
  endtask

  // One clock: combinational checks, model step + push, edge, pop + compare.
  task automatic tick(input string name);
    exp_t e;
    logic [31:0] n4, np;
    #1;
    tests++;
    if (Redirect !== (JrEn | BranchTaken | JumpEn)) begin
      failed++;
      $display("FAIL %s redirect: got %b expected %b", name, Redirect, JrEn | BranchTaken | JumpEn);
    end
    if (m_init) begin
      n4 = m_pc + 32'd4;
      tests++;
      if (PCPlus4 !== n4) begin
        failed++;
        $display("FAIL %s pcplus4: got %h expected %h", name, PCPlus4, n4);
      end
    end
    if (Reset) begin
      m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0; m_init = 1;
    end else begin
      n4 = m_pc + 32'd4;
      if (JrEn)             np = JrAddr;
      else if (BranchTaken) np = BranchBase + BranchOffset;
      else if (JumpEn)      np = {m_pc4[31:28], JumpTarget28};
      else if (Stall)       np = m_pc;
      else                  np = n4;
      if (JrEn || BranchTaken || JumpEn) begin
        m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      end else if (!Stall) begin
        m_instr = imem(m_pc); m_pc4 = n4; m_valid = 1'b1;
      end
      m_pc = np;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    tests++;
    if (PC !== e.pc || IFID_Instr !== e.instr || IFID_PCPlus4 !== e.pc4 || IFID_Valid !== e.valid) begin
      failed++;
      $display("FAIL %s state: got pc=%h instr=%h pc4=%h v=%b expected pc=%h instr=%h pc4=%h v=%b",
               name, PC, IFID_Instr, IFID_PCPlus4, IFID_Valid, e.pc, e.instr, e.pc4, e.valid);
    end else begin
      $display("[TB] %s: pc=%h ifid_instr=%h ifid_pc4=%h valid=%b", name, PC, IFID_Instr, IFID_PCPlus4, IFID_Valid);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1;
    tick("reset0");
    tick("reset1");
    tests++;
    if (PC !== 32'd0 || IFID_Valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: got pc=%h v=%b expected pc=00000000 v=0", PC, IFID_Valid);
    end
    Reset = 0;
    tick("release");
    tests++;
    if (PC !== 32'd4 || IFID_Instr !== 32'h2008_0005 || IFID_PCPlus4 !== 32'd4 || IFID_Valid !== 1'b1) begin
      failed++;
      $display("FAIL first_fetch: got pc=%h instr=%h pc4=%h v=%b expected 4/20080005/4/1",
               PC, IFID_Instr, IFID_PCPlus4, IFID_Valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_instr;
    clear_inputs();
    tick("seq1");
    tick("seq2");
    held_instr = IFID_Instr;
    Stall = 1;
    tick("stall1");
    tick("stall2");
    tests++;
    if (PC !== 32'd12 || IFID_PCPlus4 !== 32'd12 || IFID_Instr !== held_instr || Redirect !== 1'b0) begin
      failed++;
      $display("FAIL stall_hold: got pc=%h pc4=%h instr=%h redir=%b expected pc=c pc4=c instr=%h redir=0",
               PC, IFID_PCPlus4, IFID_Instr, Redirect, held_instr);
    end
    Stall = 0;
  endtask

  task automatic test_jump();
    clear_inputs();
    JrEn = 1; JrAddr = 32'h4000_000C;
    tick("jr_setup");
    JrEn = 0;
    tick("fetch_4000000c");
    JumpEn = 1; JumpTarget28 = 28'h000_0040;
    tick("jump");
    JumpEn = 0;
    tests++;
    if (PC !== 32'h4000_0040 || IFID_Valid !== 1'b0 || IFID_Instr !== 32'd0) begin
      failed++;
      $display("FAIL jump: got pc=%h v=%b instr=%h expected 40000040/0/00000000", PC, IFID_Valid, IFID_Instr);
    end
    tick("after_jump");
    tests++;
    if (IFID_Valid !== 1'b1 || IFID_PCPlus4 !== 32'h4000_0044) begin
      failed++;
      $display("FAIL jump_refill: got v=%b pc4=%h expected 1/40000044", IFID_Valid, IFID_PCPlus4);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    BranchTaken = 1; BranchBase = 32'h0000_0020; BranchOffset = 32'hFFFF_FFF0;
    tick("branch");
    BranchTaken = 0;
    tests++;
    if (PC !== 32'h0000_0010 || IFID_Valid !== 1'b0) begin
      failed++;
      $display("FAIL branch: got pc=%h v=%b expected 00000010/0", PC, IFID_Valid);
    end
    tick("after_branch");
  endtask

  task automatic test_priority();
    clear_inputs();
    JrEn = 1; JrAddr = 32'h0000_0100;
    BranchTaken = 1; BranchBase = 32'h0000_0200; BranchOffset = 32'h0000_0040;
    JumpEn = 1; JumpTarget28 = 28'h000_0300;
    Stall = 1;
    #1;
    tests++;
    if (Redirect !== 1'b1) begin
      failed++;
      $display("FAIL priority_redirect: got %b expected 1", Redirect);
    end
    tick("all_redirects");
    clear_inputs();
    tests++;
    if (PC !== 32'h0000_0100 || IFID_Valid !== 1'b0) begin
      failed++;
      $display("FAIL priority: got pc=%h v=%b expected 00000100/0", PC, IFID_Valid);
    end
    BranchTaken = 1; JumpEn = 1; Stall = 1;
    tick("branch_over_jump");
    clear_inputs();
    tick("after_priority");
  endtask

  task automatic test_reset_redirect();
    clear_inputs();
    JrEn = 1; JrAddr = 32'hFFFF_FFFC;
    tick("jr_top");
    JrEn = 0;
    Reset = 1; BranchTaken = 1; BranchBase = 32'h1234_0000; BranchOffset = 32'h10;
    tick("reset_vs_branch");
    clear_inputs();
    tests++;
    if (PC !== 32'd0 || IFID_Valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_over_branch: got pc=%h v=%b expected 00000000/0", PC, IFID_Valid);
    end
    tick("post_reset");
  endtask

  task automatic test_wrap();
    clear_inputs();
    JrEn = 1; JrAddr = 32'hFFFF_FFFC;
    tick("jr_wrap");
    JrEn = 0;
    tick("wrap");
    tests++;
    if (PC !== 32'd0 || IFID_PCPlus4 !== 32'd0 || IFID_Valid !== 1'b1) begin
      failed++;
      $display("FAIL wrap: got pc=%h pc4=%h v=%b expected 0/0/1", PC, IFID_PCPlus4, IFID_Valid);
    end
    BranchTaken = 1; BranchBase = 32'hFFFF_FFF8; BranchOffset = 32'h0000_0010;
    tick("branch_wrap");
    clear_inputs();
    JrEn = 1; JrAddr = 32'h0000_0123;
    tick("jr_misaligned");
    clear_inputs();
    tick("after_misaligned");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      Reset        = ($urandom_range(0, 19) == 0);
      Stall        = ($urandom_range(0, 2) == 0);
      JrEn         = ($urandom_range(0, 9) == 0);
      BranchTaken  = ($urandom_range(0, 9) == 0);
      JumpEn       = ($urandom_range(0, 7) == 0);
      JrAddr       = $urandom;
      BranchBase   = $urandom;
      BranchOffset = $urandom;
      JumpTarget28 = {$urandom_range(0, 32'h03FF_FFFF), 2'b00};
      tick("random");
    end
    clear_inputs();
    tick("random_end");
  endtask

  initial begin
    test_reset();
    test_stall();
    test_jump();
    test_branch();
    test_priority();
    test_reset_redirect();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
